// File: rtl/led_bar_pwm.sv
// Velocity-driven LED bar/dot display with per-LED PWM dimming and period-aligned pattern updates.
// Optional macro LED_FADE_EN: duty registers ramp by one step per period instead of jumping.
module led_bar_pwm #(
    parameter int N_LED = 16,
    parameter int VEL_W = 11,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VEL_W-1:0] velocity,
    input  logic             vel_valid,
    input  logic             mode,
    input  logic [PWM_W-1:0] brightness,
    output logic [N_LED-1:0] led_out,
    output logic             period_tick
);

    localparam int LVL_W = $clog2(N_LED + 1);
    localparam int SC_W  = VEL_W + LVL_W;

    logic [PWM_W-1:0]   r_cnt;
    logic [PWM_W-1:0]   w_cnt_next;
    logic               w_wrap;
    logic [VEL_W-1:0]   r_vel_q;
    logic [SC_W-1:0]    w_scaled;
    logic [LVL_W-1:0]   w_level;
    logic [PWM_W-1:0]   w_frac;
    logic [LVL_W-1:0]   r_level;
    logic [PWM_W-1:0]   r_frac;
    logic [2*PWM_W-1:0] w_prod;
    logic [PWM_W-1:0]   w_partial;
    logic [LVL_W-1:0]   w_dot_idx;
    logic [PWM_W-1:0]   w_tgt       [N_LED];
    logic [PWM_W-1:0]   w_duty_next [N_LED];
    logic [PWM_W-1:0]   r_duty      [N_LED];
    logic [N_LED-1:0]   w_led_next;

    assign w_cnt_next = r_cnt + 1'b1;
    assign w_wrap     = (r_cnt == '1);

    // Multiply-and-shift scaling: level is the integer LED position, frac the position within it.
    assign w_scaled = SC_W'(r_vel_q) * SC_W'(N_LED);
    assign w_level  = LVL_W'(w_scaled >> VEL_W);

    generate
        if (VEL_W >= PWM_W) begin : g_frac_trunc
            assign w_frac = PWM_W'(w_scaled[VEL_W-1:0] >> (VEL_W - PWM_W));
        end else begin : g_frac_ext
            assign w_frac = PWM_W'(w_scaled[VEL_W-1:0]);
        end
    endgenerate

    assign w_prod    = (2*PWM_W)'(brightness) * (2*PWM_W)'(r_frac);
    assign w_partial = PWM_W'(w_prod >> PWM_W);
    assign w_dot_idx = (r_level > LVL_W'(N_LED - 1)) ? LVL_W'(N_LED - 1) : r_level;

    always_comb begin
        for (int unsigned i = 0; i < N_LED; i++) begin
            w_tgt[i] = '0;
            if (mode) begin
                if (LVL_W'(i) == w_dot_idx) w_tgt[i] = brightness;
            end else if (LVL_W'(i) < r_level) begin
                w_tgt[i] = brightness;
            end else if (LVL_W'(i) == r_level) begin
                w_tgt[i] = w_partial;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_LED; i++) begin
            w_duty_next[i] = r_duty[i];
            if (w_wrap) begin
`ifdef LED_FADE_EN
                if (r_duty[i] < w_tgt[i])      w_duty_next[i] = r_duty[i] + 1'b1;
                else if (r_duty[i] > w_tgt[i]) w_duty_next[i] = r_duty[i] - 1'b1;
`else
                w_duty_next[i] = w_tgt[i];
`endif
            end
        end
    end

    // Compare against next-cycle counter and duty so led_out lines up with the visible counter value.
    always_comb begin
        for (int unsigned i = 0; i < N_LED; i++) begin
            w_led_next[i] = (w_cnt_next < w_duty_next[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_vel_q     <= '0;
            r_level     <= '0;
            r_frac      <= '0;
            led_out     <= '0;
            period_tick <= 1'b0;
            for (int unsigned i = 0; i < N_LED; i++) r_duty[i] <= '0;
        end else begin
            r_cnt       <= w_cnt_next;
            period_tick <= w_wrap;
            if (vel_valid) r_vel_q <= velocity;
            r_level     <= w_level;
            r_frac      <= w_frac;
            led_out     <= w_led_next;
            for (int unsigned i = 0; i < N_LED; i++) r_duty[i] <= w_duty_next[i];
        end
    end

endmodule

// File: tb/tb_led_bar_pwm.sv
// Randomized self-checking bench for led_bar_pwm against a period-level behavioural model.
module tb_led_bar_pwm;

    localparam int N    = 16;
    localparam int VW   = 11;
    localparam int PW   = 8;
    localparam int MAXC = (1 << PW) - 1;

    logic          clk;
    logic          rst;
    logic [VW-1:0] velocity;
    logic          vel_valid;
    logic          mode;
    logic [PW-1:0] brightness;
    logic [N-1:0]  led_out;
    logic          period_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: counter value of the current cycle, velocity that the next wrap will use,
    // and a velocity that arrived too late for the coming wrap.
    int m_cnt;
    int m_ready;
    int m_late;
    bit m_late_f;
    bit m_ticked;
    int m_duty [N];
    int on0, on8;

    led_bar_pwm #(.N_LED(N), .VEL_W(VW), .PWM_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .velocity   (velocity),
        .vel_valid  (vel_valid),
        .mode       (mode),
        .brightness (brightness),
        .led_out    (led_out),
        .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_ready = 0; m_late = 0; m_late_f = 0; m_ticked = 0;
        for (int i = 0; i < N; i++) m_duty[i] = 0;
    endtask

    task automatic load_pattern(input int v);
        int scaled, lvl, frac, tgt, br;
        scaled = v * N;
        lvl    = scaled / (1 << VW);
        frac   = (scaled % (1 << VW)) / (1 << (VW - PW));
        br     = int'(brightness);
        for (int i = 0; i < N; i++) begin
            if (mode) tgt = (i == ((lvl > N - 1) ? N - 1 : lvl)) ? br : 0;
            else if (i < lvl)  tgt = br;
            else if (i == lvl) tgt = (br * frac) / (1 << PW);
            else               tgt = 0;
`ifdef LED_FADE_EN
            if (m_duty[i] < tgt)      m_duty[i] = m_duty[i] + 1;
            else if (m_duty[i] > tgt) m_duty[i] = m_duty[i] - 1;
`else
            m_duty[i] = tgt;
`endif
        end
    endtask

    // Entered at posedge+1; checks this cycle's outputs, then advances the model over the edge.
    task automatic run_cycle(input logic valid, input logic [VW-1:0] v);
        logic [N-1:0] exp_led;
        vel_valid = valid;
        velocity  = v;
        @(negedge clk);
        exp_led = '0;
        for (int i = 0; i < N; i++) if (m_cnt < m_duty[i]) exp_led[i] = 1'b1;
        chk("led_out", 32'(led_out), 32'(exp_led));
        chk("period_tick", 32'(period_tick), 32'(m_cnt == 0 && m_ticked));
        on0 += int'(led_out[0]);
        on8 += int'(led_out[8]);
        @(posedge clk);
        if (valid) begin
            if (m_cnt <= MAXC - 2) m_ready = int'(v);
            else begin m_late = int'(v); m_late_f = 1; end
        end
        if (m_cnt == MAXC) begin
            load_pattern(m_ready);
            if (m_late_f) begin m_ready = m_late; m_late_f = 0; end
            m_ticked = 1;
        end
        m_cnt = (m_cnt + 1) % (MAXC + 1);
        #1;
    endtask

    task automatic run_to(input int target);
        while (m_cnt != target) run_cycle(1'b0, '0);
    endtask

    task automatic count_period(input string tag, input int exp0, input int exp8);
        run_to(0);
        on0 = 0; on8 = 0;
        for (int k = 0; k <= MAXC; k++) run_cycle(1'b0, '0);
`ifndef LED_FADE_EN
        chk({tag, "_led0_on"}, 32'(on0), 32'(exp0));
        chk({tag, "_led8_on"}, 32'(on8), 32'(exp8));
`endif
    endtask

    initial begin
        rst = 1'b0; velocity = '0; vel_valid = 1'b0; mode = 1'b0; brightness = 8'd255;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", 32'(led_out), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);
        rst = 1'b1;

        run_to(10);
        for (int k = 0; k < 300; k++) run_cycle(1'b0, '0);

        run_to(10); run_cycle(1'b1, 11'd1024);
        count_period("v1024", 255, 0);
        run_to(10); run_cycle(1'b1, 11'd1100);
        count_period("v1100", 255, 151);

        mode = 1'b1; brightness = 8'd100;
        run_to(20); run_cycle(1'b1, 11'd2047);
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);
        run_to(MAXC);     run_cycle(1'b1, 11'd0);
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);
        mode = 1'b0; brightness = 8'd255;
        run_to(MAXC - 1); run_cycle(1'b1, 11'd1500);
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);
        run_to(MAXC - 2); run_cycle(1'b1, 11'd2047);
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);
        brightness = 8'd0;
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);

        for (int k = 0; k < 12000; k++) begin
            logic [VW-1:0] v;
            case ($urandom % 4)
                0:       v = '0;
                1:       v = '1;
                default: v = VW'($urandom % (1 << VW));
            endcase
            if (k % 700 == 0) begin
                mode       = 1'($urandom % 2);
                brightness = ($urandom % 5 == 0) ? 8'd0 : PW'($urandom % 256);
            end
            run_cycle(1'($urandom % 48 == 0), v);
        end

        mode = 1'b0; brightness = 8'd255;
        run_to(5); run_cycle(1'b1, 11'd2047);
        run_to(0); run_to(100);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_led", 32'(led_out), 32'd0);
        chk("async_rst_tick", 32'(period_tick), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);
        run_to(30); run_cycle(1'b1, 11'd900);
        for (int k = 0; k < 600; k++) run_cycle(1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
